// File: rtl/spi_flash_sequencer.sv
// Command-level SPI NOR sequencer: turns 6809 bus cycles into READ or
// WREN / PAGE PROGRAM / RDSR-poll flash transactions over a byte shifter.
module spi_flash_sequencer #(
    parameter int          ADDR_BITS  = 12,
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter int          CS_GAP     = 4,
    parameter int          POLL_LIMIT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_ce,
    input  logic        i_enable,
    input  logic        i_Q,
    input  logic        i_RW,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic [7:0]  i_DataBus,
    output logic [7:0]  o_spi_data,
    output logic        o_MemoryReady,
    output logic        o_SPI_CS,
    output logic        o_xfer_start,
    output logic [7:0]  o_xfer_tx,
    input  logic        i_xfer_done,
    input  logic [7:0]  i_xfer_rx,
    output logic        o_timeout
);
    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, GAP} state_t;
    typedef enum logic [3:0] {
        ST_RD_CMD, ST_RD_A2, ST_RD_A1, ST_RD_A0, ST_RD_DUMMY,
        ST_WREN,
        ST_PP_CMD, ST_PP_A2, ST_PP_A1, ST_PP_A0, ST_PP_DATA,
        ST_SR_CMD, ST_SR_POLL,
        ST_DONE
    } step_t;

    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int PW = $clog2(POLL_LIMIT + 1);

    state_t        state;
    step_t         step, nxt_step;
    logic [23:0]   addr, req_addr;
    logic [7:0]    wdata;
    logic [GW-1:0] gap_cnt;
    logic [PW-1:0] poll_cnt;
    logic          window_end, poll_timeout, poll_last;
    logic          addr_unused;

    assign req_addr    = BASE_ADDR + 24'(i_ADDRESS_BUS[ADDR_BITS-1:0]);
    assign addr_unused = ^i_ADDRESS_BUS;
    assign poll_last   = (poll_cnt == PW'(POLL_LIMIT - 1));

    function automatic logic [7:0] step_byte(step_t s, logic [23:0] a, logic [7:0] d);
        case (s)
            ST_RD_CMD:            return 8'h03;
            ST_WREN:              return 8'h06;
            ST_PP_CMD:            return 8'h02;
            ST_SR_CMD:            return 8'h05;
            ST_RD_A2, ST_PP_A2:   return a[23:16];
            ST_RD_A1, ST_PP_A1:   return a[15:8];
            ST_RD_A0, ST_PP_A0:   return a[7:0];
            ST_PP_DATA:           return d;
            default:              return 8'h00;
        endcase
    endfunction

    // Successor step, and whether the current byte closes the CS window.
    always_comb begin
        nxt_step     = step;
        window_end   = 1'b0;
        poll_timeout = 1'b0;
        case (step)
            ST_RD_CMD:   nxt_step = ST_RD_A2;
            ST_RD_A2:    nxt_step = ST_RD_A1;
            ST_RD_A1:    nxt_step = ST_RD_A0;
            ST_RD_A0:    nxt_step = ST_RD_DUMMY;
            ST_RD_DUMMY: begin nxt_step = ST_DONE;   window_end = 1'b1; end
            ST_WREN:     begin nxt_step = ST_PP_CMD; window_end = 1'b1; end
            ST_PP_CMD:   nxt_step = ST_PP_A2;
            ST_PP_A2:    nxt_step = ST_PP_A1;
            ST_PP_A1:    nxt_step = ST_PP_A0;
            ST_PP_A0:    nxt_step = ST_PP_DATA;
            ST_PP_DATA:  begin nxt_step = ST_SR_CMD; window_end = 1'b1; end
            ST_SR_CMD:   nxt_step = ST_SR_POLL;
            ST_SR_POLL: begin
                poll_timeout = i_xfer_rx[0] && poll_last;
                window_end   = !i_xfer_rx[0] || poll_last;
                nxt_step     = window_end ? ST_DONE : ST_SR_POLL;
            end
            default:     nxt_step = ST_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            step          <= ST_DONE;
            addr          <= '0;
            wdata         <= '0;
            gap_cnt       <= '0;
            poll_cnt      <= '0;
            o_spi_data    <= '0;
            o_MemoryReady <= 1'b1;
            o_SPI_CS      <= 1'b1;
            o_xfer_start  <= 1'b0;
            o_xfer_tx     <= '0;
            o_timeout     <= 1'b0;
        end else begin
            o_xfer_start <= 1'b0;
            case (state)
                IDLE: if (spi_ce && i_enable && i_Q) begin
                    addr          <= req_addr;
                    wdata         <= i_DataBus;
                    step          <= i_RW ? ST_RD_CMD : ST_WREN;
                    state         <= SETUP;
                    o_MemoryReady <= 1'b0;
                    o_SPI_CS      <= 1'b0;
                    if (!i_RW) o_timeout <= 1'b0;
                end
                SETUP: begin
                    state        <= ISSUE;
                    o_xfer_start <= 1'b1;
                    o_xfer_tx    <= step_byte(step, addr, wdata);
                end
                ISSUE: state <= WAIT;
                WAIT: if (i_xfer_done) begin
                    if (step == ST_RD_DUMMY) o_spi_data <= i_xfer_rx;
                    if (step == ST_SR_CMD)   poll_cnt   <= '0;
                    if (step == ST_SR_POLL)  poll_cnt   <= poll_cnt + 1'b1;
                    step <= nxt_step;
                    if (window_end) begin
                        state    <= GAP;
                        o_SPI_CS <= 1'b1;
                        gap_cnt  <= GW'(CS_GAP - 1);
                        if (poll_timeout) o_timeout <= 1'b1;
                    end else begin
                        state        <= ISSUE;
                        o_xfer_start <= 1'b1;
                        o_xfer_tx    <= step_byte(nxt_step, addr, wdata);
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (step == ST_PP_CMD || step == ST_SR_CMD) begin
                        // Write sequence continues with its next command window.
                        state    <= SETUP;
                        o_SPI_CS <= 1'b0;
                    end else begin
                        state         <= IDLE;
                        o_MemoryReady <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Bench for spi_flash_sequencer: two configurations share one shifter model and
// one monitor; every transaction is compared against a byte-list reference.
module tb_spi_flash_sequencer;
    localparam int          AB     = 12;
    localparam logic [23:0] BASE_A = 24'h000000;
    localparam logic [23:0] BASE_B = 24'hFFFF00;
    localparam int          GAP_A  = 4, GAP_B = 3;
    localparam int          LIM_A  = 1000, LIM_B = 4;

    logic clk = 0, reset = 1;
    always #5 clk = ~clk;

    logic        spi_ce = 0, i_enable = 0, i_Q = 0, i_RW = 1;
    logic [15:0] addr_bus = 0;
    logic [7:0]  data_bus = 0;
    logic        x_done = 0;
    logic [7:0]  x_rx = 0;
    logic        sel = 0;

    logic [7:0] a_data, b_data, a_tx, b_tx;
    logic       a_rdy, b_rdy, a_cs, b_cs, a_start, b_start, a_to, b_to;
    logic       a_ce, b_ce, a_done, b_done;
    logic [7:0] s_data, s_tx;
    logic       s_rdy, s_cs, s_start, s_to;

    assign a_ce   = spi_ce & ~sel;
    assign b_ce   = spi_ce & sel;
    assign a_done = x_done & ~sel;
    assign b_done = x_done & sel;
    assign s_data  = sel ? b_data  : a_data;
    assign s_tx    = sel ? b_tx    : a_tx;
    assign s_rdy   = sel ? b_rdy   : a_rdy;
    assign s_cs    = sel ? b_cs    : a_cs;
    assign s_start = sel ? b_start : a_start;
    assign s_to    = sel ? b_to    : a_to;

    spi_flash_sequencer #(.ADDR_BITS(AB), .BASE_ADDR(BASE_A), .CS_GAP(GAP_A), .POLL_LIMIT(LIM_A)) dut_a (
        .clk(clk), .reset(reset), .spi_ce(a_ce), .i_enable(i_enable), .i_Q(i_Q), .i_RW(i_RW),
        .i_ADDRESS_BUS(addr_bus), .i_DataBus(data_bus), .o_spi_data(a_data), .o_MemoryReady(a_rdy),
        .o_SPI_CS(a_cs), .o_xfer_start(a_start), .o_xfer_tx(a_tx), .i_xfer_done(a_done),
        .i_xfer_rx(x_rx), .o_timeout(a_to));

    spi_flash_sequencer #(.ADDR_BITS(AB), .BASE_ADDR(BASE_B), .CS_GAP(GAP_B), .POLL_LIMIT(LIM_B)) dut_b (
        .clk(clk), .reset(reset), .spi_ce(b_ce), .i_enable(i_enable), .i_Q(i_Q), .i_RW(i_RW),
        .i_ADDRESS_BUS(addr_bus), .i_DataBus(data_bus), .o_spi_data(b_data), .o_MemoryReady(b_rdy),
        .o_SPI_CS(b_cs), .o_xfer_start(b_start), .o_xfer_tx(b_tx), .i_xfer_done(b_done),
        .i_xfer_rx(x_rx), .o_timeout(b_to));

    int checks = 0, errors = 0;
    int log_q[$], gap_q[$], rx_q[$], st_q[$];
    int exp_log[$], exp_gaps[$];
    int exp_data, exp_to, acc_rdy, acc_to, waited_ok;
    int m_data[2], m_to[2];
    bit stray_en = 0;

    // Shifter model: done arrives 1..3 cycles after start; optional stray dones
    // land in ISSUE or GAP cycles, where the sequencer must ignore them.
    bit sh_busy = 0;
    int sh_cnt = 0, sh_pend = 0;
    initial forever begin
        @(negedge clk);
        x_done = 0;
        if (reset) begin
            sh_busy = 0;
        end else if (sh_busy) begin
            if (sh_cnt == 0) begin x_done = 1; x_rx = 8'(sh_pend); sh_busy = 0; end
            else sh_cnt--;
        end else if (s_start) begin
            sh_busy = 1;
            sh_cnt  = $urandom_range(0, 2);
            sh_pend = (rx_q.size() > 0) ? rx_q.pop_front() : 0;
            if (stray_en) begin x_done = 1; x_rx = 8'hEE; end
        end else if (stray_en && s_cs && !s_rdy) begin
            x_done = 1; x_rx = 8'hEE;
        end
    end

    // Monitor: tx byte log with 256 marking CS rising; CS-high run lengths.
    bit pcs = 1, prdy = 1;
    int hi = 0;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            pcs = 1; prdy = 1; hi = 0;
        end else begin
            if (s_start) begin
                checks++;
                if (s_cs !== 1'b0) begin errors++; $display("FAIL start_cs: cs=%b required 0", s_cs); end
                log_q.push_back(int'(s_tx));
            end
            if (s_cs && !pcs) log_q.push_back(256);
            if (!s_cs && pcs && hi > 0) begin gap_q.push_back(hi); hi = 0; end
            if (s_cs && !s_rdy) hi++;
            if (s_rdy && !prdy) begin gap_q.push_back(hi); hi = 0; end
            pcs = s_cs; prdy = s_rdy;
        end
    end

    function automatic bit q_eq(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] != b[i]) return 0;
        return 1;
    endfunction

    // Builds the expected byte stream from the command rules, then runs one bus cycle.
    task automatic do_txn(input bit d, input bit rw, input logic [15:0] addr, input logic [7:0] data, input bit stray);
        int base, a24, gap, lim, n, to;
        base = d ? int'(BASE_B) : int'(BASE_A);
        gap  = d ? GAP_B : GAP_A;
        lim  = d ? LIM_B : LIM_A;
        a24  = (base + (int'(addr) % (1 << AB))) % (1 << 24);
        sel = d;
        log_q.delete(); gap_q.delete(); rx_q.delete(); exp_log.delete(); exp_gaps.delete();
        if (rw) begin
            repeat (4) rx_q.push_back($urandom_range(0, 255));
            rx_q.push_back(int'(data));
            exp_log = '{3, (a24 >> 16) & 255, (a24 >> 8) & 255, a24 & 255, 0, 256};
            exp_gaps.push_back(gap);
            m_data[d] = int'(data);
        end else begin
            repeat (7) rx_q.push_back($urandom_range(0, 255));
            n = 0; to = 1;
            foreach (st_q[i]) begin
                n++;
                rx_q.push_back(st_q[i]);
                if ((st_q[i] & 1) == 0) begin to = 0; break; end
                if (n == lim) break;
            end
            exp_log = '{6, 256, 2, (a24 >> 16) & 255, (a24 >> 8) & 255, a24 & 255, int'(data), 256, 5};
            repeat (n) exp_log.push_back(0);
            exp_log.push_back(256);
            repeat (3) exp_gaps.push_back(gap);
            m_to[d] = to;
        end
        exp_data = m_data[d];
        exp_to   = m_to[d];
        stray_en = stray;
        @(negedge clk);
        spi_ce = 1; i_enable = 1; i_Q = 1; i_RW = rw; addr_bus = addr; data_bus = data;
        @(negedge clk);
        spi_ce = 0; i_enable = 0; i_Q = 0;
        acc_rdy = s_rdy; acc_to = s_to;
        waited_ok = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            spi_ce = 0; i_enable = 0; i_Q = 0;
            if (s_rdy) begin waited_ok = 1; break; end
            if (stray && $urandom_range(0, 2) == 0) begin
                spi_ce = 1; i_enable = 1; i_Q = 1; i_RW = 1'($urandom_range(0, 1));
                addr_bus = 16'($urandom); data_bus = 8'($urandom);
            end
        end
        stray_en = 0;
        repeat (2) @(negedge clk);
        rx_q.delete();
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        checks++; if (a_data !== 8'h00 || b_data !== 8'h00) begin errors++; $display("FAIL reset_data: %h %h required 00", a_data, b_data); end
        checks++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: %b %b required 1", a_rdy, b_rdy); end
        checks++; if (a_cs !== 1'b1 || b_cs !== 1'b1) begin errors++; $display("FAIL reset_cs: %b %b required 1", a_cs, b_cs); end
        checks++; if (a_start !== 1'b0 || b_start !== 1'b0) begin errors++; $display("FAIL reset_start: %b %b required 0", a_start, b_start); end
        checks++; if (a_tx !== 8'h00 || b_tx !== 8'h00) begin errors++; $display("FAIL reset_tx: %h %h required 00", a_tx, b_tx); end
        checks++; if (a_to !== 1'b0 || b_to !== 1'b0) begin errors++; $display("FAIL reset_timeout: %b %b required 0", a_to, b_to); end
        reset = 0;
        m_data = '{0, 0}; m_to = '{0, 0};
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();
        do_txn(0, 1, 16'hF123, 8'hA5, 0);
        checks++; if (acc_rdy !== 0) begin errors++; $display("FAIL read_ready_low: got %0d required 0", acc_rdy); end
        checks++; if (waited_ok !== 1) begin errors++; $display("FAIL read_done: ready never returned"); end
        checks++; if (!q_eq(log_q, exp_log)) begin errors++; $display("FAIL read_bytes: got %p required %p", log_q, exp_log); end
        checks++; if (!q_eq(gap_q, exp_gaps)) begin errors++; $display("FAIL read_gap: got %p required %p", gap_q, exp_gaps); end
        checks++; if (s_data !== 8'(exp_data)) begin errors++; $display("FAIL read_data: got %h required %h", s_data, exp_data); end
    endtask

    task automatic test_write();
        st_q = '{3, 3, 0};
        do_txn(0, 0, 16'h0456, 8'h5A, 0);
        checks++; if (!q_eq(log_q, exp_log)) begin errors++; $display("FAIL write_bytes: got %p required %p", log_q, exp_log); end
        checks++; if (!q_eq(gap_q, exp_gaps)) begin errors++; $display("FAIL write_gaps: got %p required %p", gap_q, exp_gaps); end
        checks++; if (s_to !== 1'(exp_to)) begin errors++; $display("FAIL write_timeout: got %b required %0d", s_to, exp_to); end
        checks++; if (waited_ok !== 1 || s_rdy !== 1'b1) begin errors++; $display("FAIL write_ready: got %b required 1", s_rdy); end
        checks++; if (s_data !== 8'(exp_data)) begin errors++; $display("FAIL write_data_kept: got %h required %h", s_data, exp_data); end
    endtask

    task automatic test_timeout();
        st_q = '{1, 1, 1, 1, 1, 1, 1};
        do_txn(1, 0, 16'($urandom), 8'($urandom), 0);
        checks++; if (!q_eq(log_q, exp_log)) begin errors++; $display("FAIL to_bytes: got %p required %p", log_q, exp_log); end
        checks++; if (s_to !== 1'b1 || exp_to != 1) begin errors++; $display("FAIL to_set: got %b model %0d required 1", s_to, exp_to); end
        checks++; if (waited_ok !== 1) begin errors++; $display("FAIL to_idle: ready never returned"); end
        st_q = '{0};
        do_txn(1, 0, 16'($urandom), 8'($urandom), 0);
        checks++; if (acc_to !== 0) begin errors++; $display("FAIL to_clear_accept: got %0d required 0", acc_to); end
        checks++; if (s_to !== 1'(exp_to)) begin errors++; $display("FAIL to_clear: got %b required %0d", s_to, exp_to); end
        checks++; if (!q_eq(log_q, exp_log)) begin errors++; $display("FAIL to_clear_bytes: got %p required %p", log_q, exp_log); end
    endtask

    task automatic test_base_wrap();
        do_txn(1, 1, 16'h7123, 8'($urandom), 0);
        checks++; if (!q_eq(log_q, exp_log) || exp_log[3] != 8'h23 || exp_log[1] != 0) begin
            errors++; $display("FAIL wrap_bytes: got %p required %p", log_q, exp_log); end
        checks++; if (!q_eq(gap_q, exp_gaps)) begin errors++; $display("FAIL wrap_gap: got %p required %p", gap_q, exp_gaps); end
        checks++; if (s_data !== 8'(exp_data)) begin errors++; $display("FAIL wrap_data: got %h required %h", s_data, exp_data); end
    endtask

    task automatic test_stray();
        do_txn(0, 1, 16'($urandom), 8'($urandom), 1);
        checks++; if (!q_eq(log_q, exp_log)) begin errors++; $display("FAIL stray_bytes: got %p required %p", log_q, exp_log); end
        checks++; if (s_data !== 8'(exp_data)) begin errors++; $display("FAIL stray_data: got %h required %h", s_data, exp_data); end
        checks++; if (!q_eq(gap_q, exp_gaps)) begin errors++; $display("FAIL stray_gap: got %p required %p", gap_q, exp_gaps); end
    endtask

    task automatic test_reset_mid();
        int seen;
        sel = 0; log_q.delete(); gap_q.delete(); rx_q.delete();
        @(negedge clk);
        spi_ce = 1; i_enable = 1; i_Q = 1; i_RW = 0; addr_bus = 16'h0ABC; data_bus = 8'h11;
        @(negedge clk);
        spi_ce = 0; i_enable = 0; i_Q = 0;
        seen = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (log_q.size() >= 4) begin seen = 1; break; end
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL mid_reach_addr: log %p", log_q); end
        reset = 1;
        @(negedge clk);
        checks++; if (s_cs !== 1'b1 || s_start !== 1'b0 || s_rdy !== 1'b1) begin
            errors++; $display("FAIL mid_reset: cs=%b start=%b ready=%b required 1 0 1", s_cs, s_start, s_rdy); end
        reset = 0;
        m_data = '{0, 0}; m_to = '{0, 0};
        repeat (2) @(negedge clk);
        do_txn(0, 1, 16'($urandom), 8'($urandom), 0);
        checks++; if (!q_eq(log_q, exp_log)) begin errors++; $display("FAIL mid_read_bytes: got %p required %p", log_q, exp_log); end
        checks++; if (s_data !== 8'(exp_data)) begin errors++; $display("FAIL mid_read_data: got %h required %h", s_data, exp_data); end
    endtask

    task automatic test_back_to_back();
        bit d, rw;
        for (int t = 0; t < 12; t++) begin
            d  = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            st_q.delete();
            for (int k = 0; k < 6; k++) st_q.push_back($urandom_range(0, 255) | (($urandom_range(0, 2) != 0) ? 1 : 0));
            st_q[5] = st_q[5] & 8'hFE;
            do_txn(d, rw, 16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            checks++; if (!q_eq(log_q, exp_log)) begin errors++; $display("FAIL b2b_bytes[%0d]: got %p required %p", t, log_q, exp_log); end
            checks++; if (s_data !== 8'(exp_data) || s_to !== 1'(exp_to)) begin
                errors++; $display("FAIL b2b_state[%0d]: data %h to %b required %h %0d", t, s_data, s_to, exp_data, exp_to); end
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_base_wrap();
        test_stray();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
